// File: rtl/multicycle_alu.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle logic/arith/shift ops, iterative
// shift-add MUL, and a restoring DIV that is only built when ALU_DIV_EN is defined.
module multicycle_alu #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [3:0]       aluSignals,
    input  logic [WIDTH-1:0] firstOperand,
    input  logic [WIDTH-1:0] secondOperand,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] resultHi,
    output logic             zeroFlag,
    output logic             carryFlag,
    output logic             overFlowFlag,
    output logic             negativeFlag
);
    typedef enum logic [1:0] {IDLE, HOLD, BUSY} state_t;

    localparam logic [3:0] OP_NOT = 4'd1;
    localparam logic [3:0] OP_INC = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_MOV = 4'd4;
    localparam logic [3:0] OP_ADD = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'd12;
`endif
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
    logic             z_q, z_d, c_q, c_d, v_q, v_d, n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // opa: multiplicand or divisor; lo: multiplier->product low or dividend->quotient;
    // hi: partial product high or partial remainder.
    logic [WIDTH-1:0] opa_q, opa_d, lo_q, lo_d, hi_q, hi_d;
`ifdef ALU_DIV_EN
    logic             is_div_q, is_div_d;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi, div_lo;
`endif

    logic             accept, is_iter;
    logic [WIDTH:0]   add_w, sub_w, inc_w, dec_w, mul_sum;
    logic [WIDTH-1:0] sc_res, step_hi, step_lo;
    logic             sc_c, sc_v;

    assign inReady  = (state_q == IDLE) || ((state_q == HOLD) && outReady);
    assign accept   = inValid && inReady;
    assign outValid = (state_q == HOLD);
    assign result       = res_q;
    assign resultHi     = res_hi_q;
    assign zeroFlag     = z_q;
    assign carryFlag    = c_q;
    assign overFlowFlag = v_q;
    assign negativeFlag = n_q;

`ifdef ALU_DIV_EN
    assign is_iter = (aluSignals == OP_MUL) || (aluSignals == OP_DIV);
`else
    assign is_iter = (aluSignals == OP_MUL);
`endif

    always_comb begin
        add_w  = {1'b0, firstOperand} + {1'b0, secondOperand};
        sub_w  = {1'b0, firstOperand} - {1'b0, secondOperand};
        inc_w  = {1'b0, firstOperand} + {{WIDTH{1'b0}}, 1'b1};
        dec_w  = {1'b0, firstOperand} - {{WIDTH{1'b0}}, 1'b1};
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (aluSignals)
            OP_NOT: sc_res = ~firstOperand;
            OP_INC: begin
                {sc_c, sc_res} = inc_w;
                sc_v = (firstOperand == MAX_POS);
            end
            OP_DEC: begin
                {sc_c, sc_res} = dec_w;
                sc_v = (firstOperand == MIN_NEG);
            end
            OP_MOV: sc_res = firstOperand;
            OP_ADD: begin
                {sc_c, sc_res} = add_w;
                sc_v = (firstOperand[WIDTH-1] == secondOperand[WIDTH-1]) &&
                       (add_w[WIDTH-1] != firstOperand[WIDTH-1]);
            end
            OP_SUB: begin
                {sc_c, sc_res} = sub_w;
                sc_v = (firstOperand[WIDTH-1] != secondOperand[WIDTH-1]) &&
                       (sub_w[WIDTH-1] != firstOperand[WIDTH-1]);
            end
            OP_AND: sc_res = firstOperand & secondOperand;
            OP_OR:  sc_res = firstOperand | secondOperand;
            OP_SHL: sc_res = (secondOperand >= WIDTH_V) ? '0 : firstOperand << secondOperand;
            OP_SHR: sc_res = (secondOperand >= WIDTH_V) ? '0 : firstOperand >> secondOperand;
            default: ;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand, then shift {hi,lo} right.
    assign mul_sum = {1'b0, hi_q} + ({1'b0, opa_q} & {(WIDTH+1){lo_q[0]}});
    assign step_hi = mul_sum[WIDTH:1];
    assign step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
    // A zero divisor naturally yields an all-ones quotient and the dividend as remainder.
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opa_q});
    assign div_hi    = div_ge ? (div_shift[WIDTH-1:0] - opa_q) : div_shift[WIDTH-1:0];
    assign div_lo    = {lo_q[WIDTH-2:0], div_ge};
`endif

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
`ifdef ALU_DIV_EN
        is_div_d = is_div_q;
`endif
        case (state_q)
            IDLE: ;
            HOLD: if (outReady) state_d = IDLE;
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                hi_d  = step_hi;
                lo_d  = step_lo;
`ifdef ALU_DIV_EN
                if (is_div_q) begin
                    hi_d = div_hi;
                    lo_d = div_lo;
                end
`endif
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = HOLD;
                    res_d    = lo_d;
                    res_hi_d = hi_d;
                    z_d      = (lo_d == '0);
                    n_d      = lo_d[WIDTH-1];
                    c_d      = |hi_d;
                    v_d      = |hi_d;
`ifdef ALU_DIV_EN
                    if (is_div_q) begin
                        c_d = 1'b0;
                        v_d = (opa_q == '0);
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (is_iter) begin
                state_d = BUSY;
                cnt_d   = CNT_W'(WIDTH);
                hi_d    = '0;
                opa_d   = firstOperand;
                lo_d    = secondOperand;
`ifdef ALU_DIV_EN
                is_div_d = (aluSignals == OP_DIV);
                if (aluSignals == OP_DIV) begin
                    opa_d = secondOperand;
                    lo_d  = firstOperand;
                end
`endif
            end else begin
                state_d  = HOLD;
                res_d    = sc_res;
                res_hi_d = '0;
                z_d      = (sc_res == '0);
                n_d      = sc_res[WIDTH-1];
                c_d      = sc_c;
                v_d      = sc_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            res_q    <= '0;
            res_hi_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            cnt_q    <= '0;
            opa_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
`ifdef ALU_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
`ifdef ALU_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end
endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu against an integer-arithmetic reference model.
module tb_multicycle_alu;
    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             inValid;
    logic             inReady;
    logic [3:0]       aluSignals;
    logic [WIDTH-1:0] firstOperand;
    logic [WIDTH-1:0] secondOperand;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] resultHi;
    logic             zeroFlag, carryFlag, overFlowFlag, negativeFlag;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_alu #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(inValid), .inReady(inReady), .aluSignals(aluSignals),
        .firstOperand(firstOperand), .secondOperand(secondOperand),
        .outValid(outValid), .outReady(outReady),
        .result(result), .resultHi(resultHi),
        .zeroFlag(zeroFlag), .carryFlag(carryFlag),
        .overFlowFlag(overFlowFlag), .negativeFlag(negativeFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sval(input longint u);
        longint m = longint'(1) << WIDTH;
        return (u >= m / 2) ? u - m : u;
    endfunction

    function automatic logic ovf(input longint s);
        longint m = longint'(1) << WIDTH;
        return (s < -(m / 2)) || (s >= m / 2);
    endfunction

    // Reference: flags packed as {Z, C, V, N}; lat = clock edges from accept to outValid.
    task automatic model(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] r, output logic [WIDTH-1:0] h,
                         output logic [3:0] f, output int lat);
        longint m  = longint'(1) << WIDTH;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint rr = 0, hh = 0;
        logic c = 1'b0, v = 1'b0;
        lat = 0;
        case (op)
            4'd1:  rr = (m - 1) - ua;
            4'd2:  begin rr = (ua + 1) % m; c = (ua + 1 >= m); v = ovf(sval(ua) + 1); end
            4'd3:  begin rr = (ua + m - 1) % m; c = (ua == 0); v = ovf(sval(ua) - 1); end
            4'd4:  rr = ua;
            4'd5:  begin rr = (ua + ub) % m; c = (ua + ub >= m); v = ovf(sval(ua) + sval(ub)); end
            4'd6:  begin rr = (ua - ub + m) % m; c = (ua < ub); v = ovf(sval(ua) - sval(ub)); end
            4'd7:  rr = ua & ub;
            4'd8:  rr = ua | ub;
            4'd9:  rr = (ub >= WIDTH) ? 0 : (ua << ub) % m;
            4'd10: rr = (ub >= WIDTH) ? 0 : (ua >> ub);
            4'd11: begin
                rr = (ua * ub) % m; hh = (ua * ub) / m;
                c = (hh != 0); v = c; lat = WIDTH;
            end
`ifdef ALU_DIV_EN
            4'd12: begin
                lat = WIDTH;
                if (ub == 0) begin rr = m - 1; hh = ua; v = 1'b1; end
                else begin rr = ua / ub; hh = ua % ub; end
            end
`endif
            default: ;
        endcase
        r = WIDTH'(rr);
        h = WIDTH'(hh);
        f = {rr == 0, c, v, rr >= m / 2};
    endtask

    function automatic logic [3:0] flags_now();
        return {zeroFlag, carryFlag, overFlowFlag, negativeFlag};
    endfunction

    // Issue one op, optionally hold outReady low for `hold` cycles, then drain and check.
    task automatic do_op(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int hold);
        logic [WIDTH-1:0] er, eh, held;
        logic [3:0]       ef;
        int               lat, n, bad_busy, bad_hold;
        model(op, a, b, er, eh, ef, lat);
        @(negedge clk);
        outReady      = (hold == 0);
        inValid       = 1'b1;
        aluSignals    = op;
        firstOperand  = a;
        secondOperand = b;
        check_eq("in_ready", inReady, 1'b1);
        @(posedge clk);
        #1;
        inValid       = 1'b0;
        aluSignals    = 4'($urandom);
        firstOperand  = WIDTH'($urandom);
        secondOperand = WIDTH'($urandom);
        @(negedge clk);
        n = 0;
        bad_busy = 0;
        while (!outValid && n <= WIDTH + 4) begin
            if (inReady) bad_busy++;
            @(negedge clk);
            n++;
        end
        check_eq("latency", n, lat);
        check_eq("busy_ready", bad_busy, 0);
        held = result;
        bad_hold = 0;
        for (int i = 0; i < hold; i++) begin
            if (result !== held || !outValid || inReady) bad_hold++;
            @(negedge clk);
        end
        check_eq("hold_stable", bad_hold, 0);
        outReady = 1'b1;
        #1;
        check_eq("drain_ready", inReady, 1'b1);
        check_eq("result", result, er);
        check_eq("resultHi", resultHi, eh);
        check_eq("flags", flags_now(), ef);
        $display("op=%0d a=%h b=%h hold=%0d -> result=%h hi=%h zcvn=%b lat=%0d",
                 op, a, b, hold, result, resultHi, flags_now(), n);
        @(negedge clk);
        check_eq("drained", outValid, 1'b0);
    endtask

    initial begin
        logic [3:0]       op;
        logic [WIDTH-1:0] a, b, er, eh;
        logic [3:0]       ef;
        int               lat;

        rst_n = 1'b0; inValid = 1'b0; outReady = 1'b1;
        aluSignals = '0; firstOperand = '0; secondOperand = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", outValid, 1'b0);
        check_eq("rst_result", {resultHi, result}, '0);
        check_eq("rst_flags", flags_now(), 4'b0000);
        check_eq("rst_in_ready", inReady, 1'b1);
        rst_n = 1'b1;

        do_op(4'd5, 16'h7FFF, 16'h0001, 0);
        check_eq("add_ovf_const", {result, flags_now()}, {16'h8000, 4'b0011});

        // Back-to-back SUB then INC with inValid held high.
        @(negedge clk);
        outReady = 1'b1; inValid = 1'b1;
        aluSignals = 4'd6; firstOperand = 16'h0003; secondOperand = 16'h0005;
        @(posedge clk);
        #1;
        aluSignals = 4'd2; firstOperand = 16'hFFFF; secondOperand = WIDTH'($urandom);
        @(negedge clk);
        model(4'd6, 16'h0003, 16'h0005, er, eh, ef, lat);
        check_eq("b2b_sub", {outValid, result, flags_now()}, {1'b1, er, ef});
        check_eq("b2b_ready", inReady, 1'b1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        @(negedge clk);
        model(4'd2, 16'hFFFF, 16'h0000, er, eh, ef, lat);
        check_eq("b2b_inc", {outValid, result, flags_now()}, {1'b1, er, ef});
        @(negedge clk);
        check_eq("b2b_drained", outValid, 1'b0);

        do_op(4'd11, 16'h1234, 16'h0100, 0);
        do_op(4'd12, 16'd100, 16'd7, 0);
        do_op(4'd12, 16'd5, 16'd0, 2);
        do_op(4'd9, 16'h0001, 16'd4, 5);
        do_op(4'd9, 16'h0001, 16'd16, 0);
        do_op(4'd0, 16'h1234, 16'h5678, 1);
        do_op(4'd15, 16'hFFFF, 16'hFFFF, 0);

        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = WIDTH'($urandom);
            b  = (op == 4'd9 || op == 4'd10) ? WIDTH'($urandom_range(0, WIDTH + 3)) : WIDTH'($urandom);
            if (i % 10 == 0) b = '0;
            do_op(op, a, b, $urandom_range(0, 3));
        end

        // Reset mid-MUL: the pending 5 from the ADD must vanish immediately.
        do_op(4'd5, 16'd2, 16'd3, 0);
        @(negedge clk);
        inValid = 1'b1; aluSignals = 4'd11; firstOperand = 16'h1234; secondOperand = 16'h0100;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_out_valid", outValid, 1'b0);
        check_eq("rst_mid_result", {resultHi, result}, '0);
        check_eq("rst_mid_flags", flags_now(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_in_ready", inReady, 1'b1);
        do_op(4'd5, 16'd2, 16'd3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, handshaked successor to the combinational datapath ALU. Single-cycle ops (logic, add/sub, shifts) get a registered result after one cycle. Iterative multiply and (optionally) divide take WIDTH cycles. Sits between decode/operand-fetch and writeback in the execute stage, with valid/ready flow control on both sides and a registered Z/C/V/N flag set per result.

## Interface
- WIDTH, 16: operand/result width in bits, ≥ 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived, not to be overridden).

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- inValid  input  1  operation request present
- inReady  output  1  block can accept a request this cycle
- aluSignals  input  4  opcode: 0 NOP, 1 NOT, 2 INC, 3 DEC, 4 MOV, 5 ADD, 6 SUB, 7 AND, 8 OR, 9 SHL, 10 SHR, 11 MUL, 12 DIV, 13–15 illegal
- firstOperand  input  WIDTH  operand A
- secondOperand  input  WIDTH  operand B; the shift amount for SHL/SHR
- outValid  output  1  result/flags valid
- outReady  input  1  consumer accepts result
- result  output  WIDTH  primary result; MUL low half; DIV quotient
- resultHi  output  WIDTH  MUL high half; DIV remainder; 0 for all other ops
- zeroFlag, carryFlag, overFlowFlag, negativeFlag  output  1 each  flags of the current result

## Operation
- States:
  - IDLE (no pending result)
  - HOLD (outValid=1, waiting on outReady)
  - BUSY (MUL/DIV iterating)
- Handshake:
  - Accept when inValid && inReady.
  - inReady = (IDLE) || (HOLD && outReady). It is 0 in BUSY.
  - Result drains when outValid && outReady.
- Single-cycle op accepted: result and flags registered at the accept edge; go to HOLD.
- MUL/DIV accepted: latch operands, clear the accumulator, counter = WIDTH, go to BUSY. One bit per cycle:
  - MUL: unsigned shift-add.
  - DIV: unsigned restoring.
  - When counter reaches 0: register results and flags, go to HOLD.
- HOLD with outReady and no new accept → IDLE. HOLD with outReady and a new accept → behaves as an accept from IDLE (back-to-back).
- All inputs are sampled only at accept. Later input changes have no effect.
- Arithmetic (all unsigned modulo 2^WIDTH unless noted):
  - INC/DEC/ADD/SUB use a WIDTH+1-bit internal result.
  - C is the carry-out for INC/ADD. For DEC/SUB it is the borrow: A<B, or A==0 for DEC.
  - V is signed overflow:
    - ADD: A,B signs equal and R sign differs.
    - SUB: A,B signs differ and R sign differs from A.
    - INC: A==0111…1.
    - DEC: A==1000…0.
    - All other ops: 0.
  - SHL/SHR are logical. A shift amount ≥ WIDTH gives 0. C=0.
  - MUL: {resultHi,result}=A*B. C=V=(resultHi≠0).
  - DIV by zero: result=all ones, resultHi=A, V=1, C=0.
  - Z = (result==0). N = result[WIDTH-1]. For MUL, Z and N use result only.
  - NOP and illegal opcodes: result=resultHi=0, Z=1, C=V=N=0. They still produce an outValid beat.
- Reset (async, any state, including mid-BUSY):
  - state IDLE, outValid=0, inReady=1 after release.
  - result, resultHi, all flags and the counter = 0. The in-flight op is discarded.

## Timing
- Single-cycle op: accept at edge k → outValid=1 from edge k. Result visible in the cycle after the accept cycle.
- MUL/DIV: accept at edge k → outValid=1 from edge k+WIDTH. This is WIDTH+1 cycles from request to visible result. inReady=0 for edges k+1…k+WIDTH.
- Throughput: with outReady held at 1, one single-cycle op per clock. MUL/DIV: one per WIDTH+1 clocks.
- result, resultHi and flags are stable while outValid && !outReady.
- inReady depends combinationally on outReady. There is no other input-to-output combinational path.

## Configuration
- ALU_DIV_EN:
  - Defined: the restoring divider is built and opcode 12 behaves as DIV above.
  - Undefined: no divider logic. Opcode 12 is treated as illegal (single-cycle, result=resultHi=0, Z=1).
  - MUL is always present.

## Test plan
- WIDTH=16, ADD 0x7FFF+0x0001, outReady=1 → one cycle later result=0x8000, V=1, N=1, C=0, Z=0.
- SUB 0x0003−0x0005 then back-to-back INC 0xFFFF, outReady=1 → 0xFFFE with C=1, N=1; next cycle 0x0000 with C=1, Z=1; inReady stays 1.
- MUL 0x1234×0x0100 → outValid exactly 16 cycles after accept, result=0x3400, resultHi=0x0012, C=V=1. inReady=0 throughout BUSY.
- DIV 100/7 (ALU_DIV_EN) → result=14, resultHi=2. DIV 5/0 → result=0xFFFF, resultHi=5, V=1. Without the macro, DIV 100/7 → result=0, Z=1 after 1 cycle.
- Backpressure: SHL 0x0001 by 4 with outReady=0 for 5 cycles → result=0x0010 held stable, inReady=0 until outReady=1. SHL by 16 → 0.
- Assert rst_n=0 mid-MUL (cycle 8) → outValid, result, flags = 0 immediately. After release, inReady=1 and a new ADD 2+3 returns 5.
